// File: rtl/julia_pkg.sv
`default_nettype none
// ============================================================================
// Module      : julia_pkg
// Description : Shared fixed-point constants, raster defaults, FSM encoding
//               and the Q4.12 saturation helper for the Julia renderer.
// Revision    : 1.0 - initial release
// ============================================================================
package julia_pkg;

    localparam int FRAC     = 12;
    localparam int FXW      = 16;
    localparam int H_PX_DEF = 800;
    localparam int V_PX_DEF = 480;
    localparam int ADDR_W   = 19;

    // |z|^2 escape threshold (4.0) in the raw product scale of 2*FRAC bits
    localparam logic signed [32:0] FOUR_RAW = 33'sd4 <<< (2 * FRAC);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ITER  = 3'd2,
        ST_WRITE = 3'd3,
        ST_NEXT  = 3'd4
    } state_e;

    // Clamp a wide intermediate into the signed 16-bit coordinate range
    function automatic logic signed [FXW-1:0] sat_fx(input logic signed [33:0] v);
        if (v > 34'sd32767) begin
            return 16'sh7FFF;
        end else if (v < -34'sd32768) begin
            return 16'sh8000;
        end else begin
            return v[FXW-1:0];
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/julia_iter_step.sv
`default_nettype none
// ============================================================================
// Module      : julia_iter_step
// Description : One combinational z <- z^2 + c step in Q4.12 with escape test
//               on the current z and saturated next-state outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module julia_iter_step
    import julia_pkg::*;
(
    input  logic signed [FXW-1:0] zr_i,
    input  logic signed [FXW-1:0] zi_i,
    input  logic signed [FXW-1:0] cre_i,
    input  logic signed [FXW-1:0] cim_i,
    output logic signed [FXW-1:0] zr_o,
    output logic signed [FXW-1:0] zi_o,
    output logic                  escape_o
);

    logic signed [31:0] w_zr_ext;
    logic signed [31:0] w_zi_ext;
    logic signed [31:0] w_p_rr;
    logic signed [31:0] w_p_ii;
    logic signed [31:0] w_p_ri;
    logic signed [32:0] w_mag;
    logic signed [33:0] w_diff;
    logic signed [33:0] w_two_ri;
    logic signed [33:0] w_re_sum;
    logic signed [33:0] w_im_sum;

    // Raw products stay at 2*FRAC fractional bits until the final shift
    always_comb begin
        w_zr_ext = 32'(zr_i);
        w_zi_ext = 32'(zi_i);
        w_p_rr   = w_zr_ext * w_zr_ext;
        w_p_ii   = w_zi_ext * w_zi_ext;
        w_p_ri   = w_zr_ext * w_zi_ext;
        w_mag    = 33'(w_p_rr) + 33'(w_p_ii);
        escape_o = (w_mag >= FOUR_RAW);
        w_diff   = 34'(w_p_rr) - 34'(w_p_ii);
        w_two_ri = 34'(w_p_ri) <<< 1;
        w_re_sum = (w_diff >>> FRAC) + 34'(cre_i);
        w_im_sum = (w_two_ri >>> FRAC) + 34'(cim_i);
        zr_o     = sat_fx(w_re_sum);
        zi_o     = sat_fx(w_im_sum);
    end

endmodule
`default_nettype wire

// File: rtl/julia_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module      : julia_frame_renderer
// Description : Escape-time Julia renderer; walks the raster in panel scan
//               order and writes one 8-bit iteration count per pixel through
//               a valid/ready frame-buffer write port.
// Revision    : 1.0 - initial release
// ============================================================================
module julia_frame_renderer
    import julia_pkg::*;
#(
    parameter int H_PX     = H_PX_DEF,
    parameter int V_PX     = V_PX_DEF,
    parameter int MAX_ITER = 64
) (
    input  logic                     i_CLK,
    input  logic                     i_RSTn,
    input  logic                     i_Start,
    input  logic signed [FXW-1:0]    i_CRe,
    input  logic signed [FXW-1:0]    i_CIm,
    input  logic signed [FXW-1:0]    i_XMin,
    input  logic signed [FXW-1:0]    i_YMax,
    input  logic signed [FXW-1:0]    i_Step,
    output logic                     o_Busy,
    output logic                     o_Done,
    output logic                     o_WrEn,
    output logic [ADDR_W-1:0]        o_WrAddr,
    output logic [7:0]               o_WrData,
    input  logic                     i_WrReady
);

    localparam int XW = (H_PX > 1) ? $clog2(H_PX) : 1;
    localparam int YW = (V_PX > 1) ? $clog2(V_PX) : 1;
    localparam logic [XW-1:0] LAST_X = XW'(H_PX - 1);
    localparam logic [YW-1:0] LAST_Y = YW'(V_PX - 1);
    localparam logic [7:0]    MAX_N  = 8'(MAX_ITER);

    state_e                  state_q;
    logic signed [FXW-1:0]   cre_q;
    logic signed [FXW-1:0]   cim_q;
    logic signed [FXW-1:0]   xmin_q;
    logic signed [FXW-1:0]   step_q;
    logic signed [FXW-1:0]   pxre_q;
    logic signed [FXW-1:0]   pxim_q;
    logic signed [FXW-1:0]   zr_q;
    logic signed [FXW-1:0]   zi_q;
    logic [7:0]              n_q;
    logic [7:0]              count_q;
    logic [XW-1:0]           x_q;
    logic [YW-1:0]           y_q;
    logic [ADDR_W-1:0]       addr_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    wren_q;

    logic signed [FXW-1:0]   w_zr_nxt;
    logic signed [FXW-1:0]   w_zi_nxt;
    logic                    w_escape;

    julia_iter_step u_step (
        .zr_i     (zr_q),
        .zi_i     (zi_q),
        .cre_i    (cre_q),
        .cim_i    (cim_q),
        .zr_o     (w_zr_nxt),
        .zi_o     (w_zi_nxt),
        .escape_o (w_escape)
    );

    // Frame sequencer: pixel walk, iteration loop and write handshake
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_q <= ST_IDLE;
            cre_q   <= '0;
            cim_q   <= '0;
            xmin_q  <= '0;
            step_q  <= '0;
            pxre_q  <= '0;
            pxim_q  <= '0;
            zr_q    <= '0;
            zi_q    <= '0;
            n_q     <= '0;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wren_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_Start) begin
                        cre_q   <= i_CRe;
                        cim_q   <= i_CIm;
                        xmin_q  <= i_XMin;
                        step_q  <= i_Step;
                        pxre_q  <= i_XMin;
                        pxim_q  <= i_YMax;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    zr_q    <= pxre_q;
                    zi_q    <= pxim_q;
                    n_q     <= '0;
                    state_q <= ST_ITER;
                end
                ST_ITER: begin
                    if (w_escape) begin
                        count_q <= n_q;
                        wren_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end else if (n_q == MAX_N) begin
                        count_q <= MAX_N;
                        wren_q  <= 1'b1;
                        state_q <= ST_WRITE;
                    end else begin
                        zr_q <= w_zr_nxt;
                        zi_q <= w_zi_nxt;
                        n_q  <= n_q + 8'd1;
                    end
                end
                ST_WRITE: begin
                    if (i_WrReady) begin
                        wren_q  <= 1'b0;
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (x_q == LAST_X && y_q == LAST_Y) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        if (x_q == LAST_X) begin
                            x_q    <= '0;
                            y_q    <= y_q + YW'(1);
                            pxre_q <= xmin_q;
                            pxim_q <= pxim_q - step_q;
                        end else begin
                            x_q    <= x_q + XW'(1);
                            pxre_q <= pxre_q + step_q;
                        end
                        addr_q  <= addr_q + ADDR_W'(1);
                        state_q <= ST_LOAD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_Busy   = busy_q;
    assign o_Done   = done_q;
    assign o_WrEn   = wren_q;
    assign o_WrAddr = addr_q;
    assign o_WrData = count_q;

endmodule
`default_nettype wire

// File: tb/tb_julia_frame_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_julia_frame_renderer
// Description : Directed self-checking bench for julia_frame_renderer on a
//               4x2 raster with hand-computed iteration counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_julia_frame_renderer;

    logic        i_CLK;
    logic        i_RSTn;
    logic        i_Start;
    logic [15:0] i_CRe;
    logic [15:0] i_CIm;
    logic [15:0] i_XMin;
    logic [15:0] i_YMax;
    logic [15:0] i_Step;
    logic        o_Busy;
    logic        o_Done;
    logic        o_WrEn;
    logic [18:0] o_WrAddr;
    logic [7:0]  o_WrData;
    logic        i_WrReady;

    int          n_vec;
    int          n_err;
    logic [7:0]  exp_d [8];

    julia_frame_renderer #(
        .H_PX     (4),
        .V_PX     (2),
        .MAX_ITER (64)
    ) dut (
        .i_CLK     (i_CLK),
        .i_RSTn    (i_RSTn),
        .i_Start   (i_Start),
        .i_CRe     (i_CRe),
        .i_CIm     (i_CIm),
        .i_XMin    (i_XMin),
        .i_YMax    (i_YMax),
        .i_Step    (i_Step),
        .o_Busy    (o_Busy),
        .o_Done    (o_Done),
        .o_WrEn    (o_WrEn),
        .o_WrAddr  (o_WrAddr),
        .o_WrData  (o_WrData),
        .i_WrReady (i_WrReady)
    );

    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input logic [63:0] packed_d);
        for (int i = 0; i < 8; i++) begin
            exp_d[i] = packed_d[63 - 8*i -: 8];
        end
    endtask

    // Runs one frame from a negedge; returns at a negedge with the DUT idle
    task automatic run_frame(input string tag,
                             input logic [15:0] cre, input logic [15:0] cim,
                             input logic [15:0] xmin, input logic [15:0] ymax,
                             input logic [15:0] step,
                             input int stall_addr, input int stall_len,
                             input int bump_cyc, input int exp_first,
                             input int exp_done);
        int          cyc;
        int          nwr;
        int          stalled;
        int          first_wr;
        int          done_cyc;
        bit          done_seen;
        logic [18:0] hold_a;
        logic [7:0]  hold_d;
        cyc = 0; nwr = 0; stalled = 0; first_wr = -1; done_cyc = -1;
        done_seen = 1'b0; hold_a = '0; hold_d = '0;
        i_CRe = cre; i_CIm = cim; i_XMin = xmin; i_YMax = ymax; i_Step = step;
        i_WrReady = 1'b1;
        i_Start = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
        while (!done_seen && cyc < 3000) begin
            cyc++;
            if (cyc == 1) check({tag, " busy_after_start"}, 32'(o_Busy), 32'd1);
            i_Start = 1'b0;
            if (cyc == bump_cyc) begin
                i_CRe = 16'h0800; i_CIm = 16'h0800; i_Start = 1'b1;
            end
            if (o_Done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check({tag, " busy_at_done"}, 32'(o_Busy), 32'd0);
            end
            if (o_WrEn) begin
                if (first_wr < 0) first_wr = cyc;
                if (int'(o_WrAddr) == stall_addr && stalled < stall_len) begin
                    if (stalled == 0) begin
                        hold_a = o_WrAddr;
                        hold_d = o_WrData;
                    end else begin
                        check({tag, " stall_addr"}, 32'(o_WrAddr), 32'(hold_a));
                        check({tag, " stall_data"}, 32'(o_WrData), 32'(hold_d));
                    end
                    stalled++;
                    i_WrReady = 1'b0;
                end else begin
                    i_WrReady = 1'b1;
                    if (nwr < 8) begin
                        check({tag, " addr"}, 32'(o_WrAddr), 32'(nwr));
                        check({tag, " data"}, 32'(o_WrData), 32'(exp_d[nwr]));
                    end
                    nwr++;
                end
            end else begin
                i_WrReady = 1'b1;
            end
            if (!done_seen) @(negedge i_CLK);
        end
        i_Start = 1'b0;
        check({tag, " done_seen"}, 32'(done_seen), 32'd1);
        check({tag, " writes"}, 32'(nwr), 32'd8);
        check({tag, " stall_cycles"}, 32'(stalled), 32'(stall_len));
        check({tag, " first_wr_cycle"}, 32'(first_wr), 32'(exp_first));
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(exp_done));
        @(negedge i_CLK);
        check({tag, " done_single"}, 32'(o_Done), 32'd0);
        check({tag, " busy_idle"}, 32'(o_Busy), 32'd0);
    endtask

    initial begin
        int spurious;
        int wait_cyc;
        n_vec = 0; n_err = 0;
        i_RSTn = 1'b0; i_Start = 1'b0; i_WrReady = 1'b1;
        i_CRe = '0; i_CIm = '0; i_XMin = '0; i_YMax = '0; i_Step = '0;
        repeat (3) @(negedge i_CLK);
        check("rst busy", 32'(o_Busy), 32'd0);
        check("rst done", 32'(o_Done), 32'd0);
        check("rst wren", 32'(o_WrEn), 32'd0);
        check("rst addr", 32'(o_WrAddr), 32'd0);
        check("rst data", 32'(o_WrData), 32'd0);
        i_RSTn = 1'b1;
        @(negedge i_CLK);

        // z = 2.0 escapes before the first update: 4 cycles per pixel
        set_exp(64'h00_00_00_00_00_00_00_00);
        run_frame("escape", 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000,
                  -1, 0, -1, 3, 33);

        // z stays at 0: every pixel hits the cap
        set_exp(64'h40_40_40_40_40_40_40_40);
        run_frame("noesc", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                  -1, 0, -1, 67, 545);

        // Five stalled cycles on pixel 2
        run_frame("bp", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                  2, 5, -1, 67, 550);

        // Rows at im=1.0 and im=0.5, re = -2.0, -1.5, -1.0, -0.5
        set_exp(64'h00_01_01_03_00_01_03_40);
        run_frame("wrap", 16'h0000, 16'h0000, 16'hE000, 16'h1000, 16'h0800,
                  -1, 0, -1, 3, 106);

        // Start pulse with a different c mid-frame must not disturb the frame
        run_frame("busystart", 16'h0000, 16'h0000, 16'hE000, 16'h1000, 16'h0800,
                  -1, 0, 30, 3, 106);

        // A fresh start after done restarts at address 0
        run_frame("restart", 16'h0000, 16'h0000, 16'hE000, 16'h1000, 16'h0800,
                  -1, 0, -1, 3, 106);

        // Asynchronous reset while iterating
        i_CRe = '0; i_CIm = '0; i_XMin = '0; i_YMax = '0; i_Step = '0;
        i_Start = 1'b1;
        @(negedge i_CLK);
        i_Start = 1'b0;
        wait_cyc = int'($urandom_range(5, 50));
        repeat (wait_cyc) @(negedge i_CLK);
        check("midrst busy_before", 32'(o_Busy), 32'd1);
        #2 i_RSTn = 1'b0;
        #1;
        check("midrst wren", 32'(o_WrEn), 32'd0);
        check("midrst busy", 32'(o_Busy), 32'd0);
        check("midrst done", 32'(o_Done), 32'd0);
        check("midrst addr", 32'(o_WrAddr), 32'd0);
        @(negedge i_CLK);
        i_RSTn = 1'b1;
        spurious = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge i_CLK);
            if (o_WrEn || o_Busy || o_Done) spurious++;
        end
        check("midrst quiet", 32'(spurious), 32'd0);

        set_exp(64'h00_00_00_00_00_00_00_00);
        run_frame("postrst", 16'h0000, 16'h0000, 16'h2000, 16'h0000, 16'h0000,
                  -1, 0, -1, 3, 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/julia_frame_renderer.md
Name: julia_frame_renderer

Overview:
- Escape-time Julia set renderer that fills the frame buffer read by the LCD timing/scanout stage.
- Walks the 800x480 raster in the same order the panel scans it: row 0 first, left to right.
- For each pixel, iterates z <- z^2 + c in signed fixed point and writes the 8-bit iteration count through a valid/ready write port.
- The downstream palette/scanout path converts counts to RGB.

Parameters:
- H_PX, 800, pixels per line (matches panel active width).
- V_PX, 480, lines per frame (matches panel active height).
- MAX_ITER, 64, iteration cap; legal range 1..255.
- FRAC, 12, fractional bits of the Q4.12 signed 16-bit fixed-point format.

Ports:
- i_CLK  in  1  pixel/system clock
- i_RSTn  in  1  asynchronous active-low reset
- i_Start  in  1  1-cycle pulse; starts a frame render (ignored while busy)
- i_CRe  in  16  signed Q4.12 real part of c; |i_CRe| < 2.0
- i_CIm  in  16  signed Q4.12 imaginary part of c; |i_CIm| < 2.0
- i_XMin  in  16  signed Q4.12 real coordinate of pixel x=0
- i_YMax  in  16  signed Q4.12 imaginary coordinate of line y=0
- i_Step  in  16  signed Q4.12 coordinate increment per pixel and per line
- o_Busy  out  1  high from the cycle after an accepted start until frame done
- o_Done  out  1  1-cycle pulse after the last pixel's write is accepted
- o_WrEn  out  1  write valid
- o_WrAddr  out  19  linear address y*H_PX + x
- o_WrData  out  8  iteration count
- i_WrReady  in  1  frame buffer accepts the write this cycle

Behaviour:
- Reset (async, i_RSTn=0): FSM to IDLE. o_Busy, o_Done, o_WrEn are 0; o_WrAddr and o_WrData are 0; all coordinate and iteration registers are 0.
- Reset mid-frame aborts immediately. No write is completed after reset assertion.
- FSM states: IDLE, LOAD, ITER, WRITE, NEXT.
- IDLE:
  - On i_Start=1, register c, XMin, YMax, Step.
  - Set x=0, y=0, addr=0, PxRe=XMin, PxIm=YMax.
  - Go to LOAD.
  - i_Start in any other state is ignored; parameter inputs are sampled only here.
- LOAD: zr<=PxRe, zi<=PxIm, n<=0; go to ITER.
- ITER, one iteration per cycle:
  - Raw 32-bit signed products: P_rr=zr*zr, P_ii=zi*zi, P_ri=zr*zi.
  - Escape when P_rr+P_ii (33-bit) >= 4<<(2*FRAC). On escape: count=n, go to WRITE.
  - Else if n==MAX_ITER: count=MAX_ITER, go to WRITE.
  - Else: zr<=((P_rr-P_ii)>>>FRAC)+CRe, zi<=((2*P_ri)>>>FRAC)+CIm, n<=n+1.
  - Update results are saturated to 16-bit signed.
  - Arithmetic right shift truncates toward -inf.
- WRITE:
  - o_WrEn=1, o_WrAddr=addr, o_WrData=count.
  - Address and data are held stable while i_WrReady=0.
  - Transfer occurs on the cycle where o_WrEn & i_WrReady; go to NEXT, o_WrEn deasserts the next cycle.
- NEXT:
  - x==H_PX-1 and y==V_PX-1: go to IDLE, o_Done=1 for one cycle, o_Busy falls in the same cycle.
  - x==H_PX-1 otherwise: x<=0, y<=y+1, PxRe<=XMin, PxIm<=PxIm-Step.
  - Otherwise: x<=x+1, PxRe<=PxRe+Step.
  - In both non-final cases addr<=addr+1 and go to LOAD.
  - Address is a running counter; no multiplier.
- Per-pixel latency:
  - 1 (LOAD) + (n+1) (ITER) + 1+stall (WRITE) + 1 (NEXT).
  - Minimum 4 cycles/pixel; maximum MAX_ITER+4 with no stall.
- Coordinate wrap is not checked. The frame extent is the caller's responsibility.

Decomposition:
- Shared package julia_pkg:
  - FRAC, fixed-point width 16, H_PX/V_PX defaults, address width 19.
  - Fixed-point constant FOUR_RAW = 4<<(2*FRAC).
  - FSM state encoding.
- One natural sub-module: julia_iter_step.
  - Combinational: zr, zi, CRe, CIm in; next zr/zi (saturated) and escape flag out.
  - Instantiated once by julia_frame_renderer; also testable standalone.

Test Plan:
- Reset -> assert i_RSTn=0 at random point mid-ITER: o_WrEn/o_Busy/o_Done=0, o_WrAddr=0 same cycle; after release, no write until a new i_Start.
- Immediate escape -> H_PX=4, V_PX=2, c=0, XMin=0x2000 (2.0), YMax=0, Step=0, i_WrReady=1, start at cycle 0: LOAD cycle 1, ITER cycle 2, o_WrEn=1 cycle 3 with addr 0, data 0x00; 8 writes, all data 0.
- Never escapes -> c=0, XMin=YMax=Step=0, MAX_ITER=64: every write data 0x40, addresses 0..7 in order, o_Done single pulse after 8th accept, o_Busy then 0.
- Backpressure -> as above, i_WrReady=0 for 5 cycles on pixel 2: o_WrEn, o_WrAddr=2, o_WrData stable all 5 cycles; exactly one accepted write per address, no duplicates.
- Line wrap/stepping -> XMin=0xE000 (-2.0), YMax=0x1000 (1.0), Step=0x0800 (0.5), c=0: compare all 8 counts and PxRe/PxIm sequence against software golden model; line 1 starts at PxRe=-2.0, PxIm=0.5.
- Start while busy -> pulse i_Start mid-frame with different c: ignored, frame results unchanged; start after o_Done begins a new frame at addr 0.
